// File: rtl/alu_issue_pkg.sv
// Shared types and encodings for the ALU issue stage: ALU operation codes,
// RV64I opcode constants and the issued-beat payload.
package alu_issue_pkg;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned REG_W  = 5;

  localparam logic [OP_W-1:0] ALU_ADD  = 4'd0;
  localparam logic [OP_W-1:0] ALU_SUB  = 4'd1;
  localparam logic [OP_W-1:0] ALU_SLL  = 4'd2;
  localparam logic [OP_W-1:0] ALU_SLT  = 4'd3;
  localparam logic [OP_W-1:0] ALU_SLTU = 4'd4;
  localparam logic [OP_W-1:0] ALU_XOR  = 4'd5;
  localparam logic [OP_W-1:0] ALU_SRL  = 4'd6;
  localparam logic [OP_W-1:0] ALU_SRA  = 4'd7;
  localparam logic [OP_W-1:0] ALU_OR   = 4'd8;
  localparam logic [OP_W-1:0] ALU_AND  = 4'd9;

  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [5:0] F6_BASE = 6'b000000;
  localparam logic [5:0] F6_ALT  = 6'b010000;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] in1;
    logic [DATA_W-1:0] in2;
    logic [REG_W-1:0]  rd;
    logic              we;
    logic              word;
    logic              illegal;
  } issue_beat_t;

  function automatic logic [DATA_W-1:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational RV64I integer decode: instruction word plus operands and PC
// in, one ALU issue beat out.
module alu_issue_decode
  import alu_issue_pkg::*;
(
  input  logic [31:0]       i_insn,
  input  logic [DATA_W-1:0] i_pc,
  input  logic [DATA_W-1:0] i_rs1,
  input  logic [DATA_W-1:0] i_rs2,
  output issue_beat_t       o_beat
);

  logic [6:0]        w_opcode;
  logic [2:0]        w_funct3;
  logic [6:0]        w_funct7;
  logic [5:0]        w_funct6;
  logic [REG_W-1:0]  w_rd;
  logic [DATA_W-1:0] w_imm_i;
  logic [DATA_W-1:0] w_imm_u;
  logic [DATA_W-1:0] w_rs1_zw;
  logic [DATA_W-1:0] w_rs1_sw;
  logic [DATA_W-1:0] w_shamt6;
  logic [DATA_W-1:0] w_shamt5_imm;
  logic [DATA_W-1:0] w_shamt5_reg;

  assign w_opcode     = i_insn[6:0];
  assign w_funct3     = i_insn[14:12];
  assign w_funct7     = i_insn[31:25];
  assign w_funct6     = i_insn[31:26];
  assign w_rd         = i_insn[11:7];
  assign w_imm_i      = {{52{i_insn[31]}}, i_insn[31:20]};
  assign w_imm_u      = sext32({i_insn[31:12], 12'd0});
  assign w_rs1_zw     = {32'd0, i_rs1[31:0]};
  assign w_rs1_sw     = sext32(i_rs1[31:0]);
  assign w_shamt6     = {58'd0, i_insn[25:20]};
  assign w_shamt5_imm = {59'd0, i_insn[24:20]};
  assign w_shamt5_reg = {59'd0, i_rs2[4:0]};

  logic [OP_W-1:0]   w_op;
  logic [DATA_W-1:0] w_in1;
  logic [DATA_W-1:0] w_in2;
  logic              w_word;
  logic              w_legal;

  // Opcode/funct decode; anything unmatched falls out as illegal.
  always_comb begin
    w_op    = ALU_ADD;
    w_in1   = '0;
    w_in2   = '0;
    w_word  = 1'b0;
    w_legal = 1'b0;
    case (w_opcode)
      OPC_OP_IMM: begin
        w_legal = 1'b1;
        w_in1   = i_rs1;
        w_in2   = w_imm_i;
        case (w_funct3)
          3'b000: w_op = ALU_ADD;
          3'b010: w_op = ALU_SLT;
          3'b011: w_op = ALU_SLTU;
          3'b100: w_op = ALU_XOR;
          3'b110: w_op = ALU_OR;
          3'b111: w_op = ALU_AND;
          3'b001: begin
            w_op    = ALU_SLL;
            w_in2   = w_shamt6;
            w_legal = (w_funct6 == F6_BASE);
          end
          default: begin
            w_in2 = w_shamt6;
            if (w_funct6 == F6_BASE)     w_op = ALU_SRL;
            else if (w_funct6 == F6_ALT) w_op = ALU_SRA;
            else                         w_legal = 1'b0;
          end
        endcase
      end
      OPC_OP: begin
        w_legal = 1'b1;
        w_in1   = i_rs1;
        w_in2   = i_rs2;
        if (w_funct7 == F7_BASE) begin
          case (w_funct3)
            3'b000:  w_op = ALU_ADD;
            3'b001:  w_op = ALU_SLL;
            3'b010:  w_op = ALU_SLT;
            3'b011:  w_op = ALU_SLTU;
            3'b100:  w_op = ALU_XOR;
            3'b101:  w_op = ALU_SRL;
            3'b110:  w_op = ALU_OR;
            default: w_op = ALU_AND;
          endcase
        end else if (w_funct7 == F7_ALT) begin
          case (w_funct3)
            3'b000:  w_op = ALU_SUB;
            3'b101:  w_op = ALU_SRA;
            default: w_legal = 1'b0;
          endcase
        end else begin
          w_legal = 1'b0;
        end
      end
      OPC_LUI: begin
        w_legal = 1'b1;
        w_in2   = w_imm_u;
      end
      OPC_AUIPC: begin
        w_legal = 1'b1;
        w_in1   = i_pc;
        w_in2   = w_imm_u;
      end
      OPC_OP_IMM_32: begin
        w_word = 1'b1;
        w_in1  = i_rs1;
        w_in2  = w_shamt5_imm;
        case (w_funct3)
          3'b000: begin
            w_legal = 1'b1;
            w_in2   = w_imm_i;
          end
          3'b001: begin
            w_op    = ALU_SLL;
            w_legal = (w_funct7 == F7_BASE);
          end
          3'b101: begin
            w_legal = 1'b1;
            if (w_funct7 == F7_BASE) begin
              w_op  = ALU_SRL;
              w_in1 = w_rs1_zw;
            end else if (w_funct7 == F7_ALT) begin
              w_op  = ALU_SRA;
              w_in1 = w_rs1_sw;
            end else begin
              w_legal = 1'b0;
            end
          end
          default: w_legal = 1'b0;
        endcase
      end
      OPC_OP_32: begin
        w_word  = 1'b1;
        w_legal = 1'b1;
        w_in1   = i_rs1;
        w_in2   = i_rs2;
        case ({w_funct7, w_funct3})
          {F7_BASE, 3'b000}: w_op = ALU_ADD;
          {F7_ALT,  3'b000}: w_op = ALU_SUB;
          {F7_BASE, 3'b001}: begin
            w_op  = ALU_SLL;
            w_in2 = w_shamt5_reg;
          end
          {F7_BASE, 3'b101}: begin
            w_op  = ALU_SRL;
            w_in1 = w_rs1_zw;
            w_in2 = w_shamt5_reg;
          end
          {F7_ALT, 3'b101}: begin
            w_op  = ALU_SRA;
            w_in1 = w_rs1_sw;
            w_in2 = w_shamt5_reg;
          end
          default: w_legal = 1'b0;
        endcase
      end
      default: w_legal = 1'b0;
    endcase
  end

  // Illegal beats are flattened to a harmless ADD 0,0 with no writeback.
  always_comb begin
    o_beat         = '0;
    o_beat.rd      = w_rd;
    o_beat.illegal = !w_legal;
    if (w_legal) begin
      o_beat.op   = w_op;
      o_beat.in1  = w_in1;
      o_beat.in2  = w_in2;
      o_beat.word = w_word;
      o_beat.we   = (w_rd != '0);
    end else begin
      o_beat.op   = ALU_ADD;
    end
  end

endmodule

// File: rtl/alu_issue.sv
// ALU issue stage: decodes one instruction per beat into a single registered
// output slot with valid/ready flow control on both sides.
module alu_issue
  import alu_issue_pkg::*;
#(
  parameter int unsigned XLEN     = 64,
  parameter logic [63:0] RESET_PC = 64'd0
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [31:0]     insn_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] rs1_val_i,
  input  logic [XLEN-1:0] rs2_val_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [OP_W-1:0] operation_o,
  output logic [XLEN-1:0] in1_o,
  output logic [XLEN-1:0] in2_o,
  output logic [4:0]      rd_o,
  output logic            we_o,
  output logic            word_o,
  output logic            illegal_o
);

  if (XLEN != DATA_W) begin : g_xlen_chk
    $error("alu_issue: only XLEN=64 is supported");
  end
  if (RESET_PC[1:0] != 2'b00) begin : g_pc_chk
    $error("alu_issue: RESET_PC must be 4-byte aligned");
  end

  issue_beat_t w_dec_beat;
  logic        w_accept;
  logic        r_valid;
  issue_beat_t r_beat;

  alu_issue_decode u_decode (
    .i_insn (insn_i),
    .i_pc   (pc_i),
    .i_rs1  (rs1_val_i),
    .i_rs2  (rs2_val_i),
    .o_beat (w_dec_beat)
  );

  assign ready_o  = !r_valid || ready_i;
  assign w_accept = valid_i && ready_o;

  // Single output slot; a new beat may replace the draining one in the same cycle.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_valid <= 1'b0;
      r_beat  <= '0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_beat  <= w_dec_beat;
    end else if (ready_i) begin
      r_valid <= 1'b0;
    end
  end

  assign valid_o     = r_valid;
  assign operation_o = r_beat.op;
  assign in1_o       = r_beat.in1;
  assign in2_o       = r_beat.in2;
  assign rd_o        = r_beat.rd;
  assign we_o        = r_beat.we;
  assign word_o      = r_beat.word;
  assign illegal_o   = r_beat.illegal;

endmodule
